// File: rtl/branch_resolve_tracker.sv
// Tracks fetch-time branch predictions through ID/EX, resolves them in EX and trains the predictor.
// Optional statistics counters are compiled in with BP_STATS_EN.
module branch_resolve_tracker #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_pred_taken,
  input  logic [PC_W-1:0] if_pred_target,
  input  logic            stall,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_cond,
  input  logic [PC_W-1:0] ex_target,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic [PC_W-1:0] upd_pc
`ifdef BP_STATS_EN
  ,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] control_cnt
`endif
);

  logic            id_valid, id_pt;
  logic [PC_W-1:0] id_pc, id_ptgt;
  logic            ex_valid, ex_pt;
  logic [PC_W-1:0] ex_pc, ex_ptgt;

  logic ctrl, act, mis;

  always_comb begin
    ctrl        = ex_valid & (ex_is_branch | ex_is_jump);
    act         = ex_is_jump | (ex_is_branch & ex_cond);
    // Target only matters when both prediction and outcome say taken.
    mis         = ex_valid & ((ex_pt != act) | (act & (ex_ptgt != ex_target)));
    flush       = mis;
    redirect_pc = '0;
    if (mis) begin
      redirect_pc = act ? ex_target : ex_pc + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid  <= 1'b0;
      id_pt     <= 1'b0;
      id_pc     <= '0;
      id_ptgt   <= '0;
      ex_valid  <= 1'b0;
      ex_pt     <= 1'b0;
      ex_pc     <= '0;
      ex_ptgt   <= '0;
      upd_valid <= 1'b0;
      upd_taken <= 1'b0;
      upd_pc    <= '0;
    end else begin
      upd_valid <= ctrl;
      upd_taken <= act & ctrl;
      upd_pc    <= ex_pc;
      if (mis) begin
        // IF instruction this cycle is wrong-path, so it is not captured.
        id_valid <= 1'b0;
        ex_valid <= 1'b0;
      end else if (stall) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid <= id_valid;
        ex_pt    <= id_pt;
        ex_pc    <= id_pc;
        ex_ptgt  <= id_ptgt;
        id_valid <= if_valid;
        id_pt    <= if_pred_taken;
        id_pc    <= if_pc;
        id_ptgt  <= if_pred_target;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_cnt <= '0;
      control_cnt    <= '0;
    end else begin
      if (mis && (mispredict_cnt != {CNT_W{1'b1}})) begin
        mispredict_cnt <= mispredict_cnt + 1'b1;
      end
      if (ctrl && (control_cnt != {CNT_W{1'b1}})) begin
        control_cnt <= control_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed table-driven bench for branch_resolve_tracker; stats checks run only with BP_STATS_EN.
module tb_branch_resolve_tracker;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_valid, if_pred_taken, stall;
  logic [PC_W-1:0] if_pc, if_pred_target, ex_target;
  logic            ex_is_branch, ex_is_jump, ex_cond;
  logic            flush, upd_valid, upd_taken;
  logic [PC_W-1:0] redirect_pc, upd_pc;
`ifdef BP_STATS_EN
  logic [CNT_W-1:0] mispredict_cnt, control_cnt;
`endif

  always #5 clk = ~clk;

  branch_resolve_tracker #(
    .PC_W (PC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .if_pred_target(if_pred_target),
    .stall         (stall),
    .ex_is_branch  (ex_is_branch),
    .ex_is_jump    (ex_is_jump),
    .ex_cond       (ex_cond),
    .ex_target     (ex_target),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_taken     (upd_taken),
    .upd_pc        (upd_pc)
`ifdef BP_STATS_EN
    ,
    .mispredict_cnt(mispredict_cnt),
    .control_cnt   (control_cnt)
`endif
  );

  typedef struct {
    logic        rst, iv, ipt, stl, br, jp, cond;
    logic [31:0] ipc, itgt, tgt;
    logic        e_fl, e_uv, e_ut, cpc;
    logic [31:0] e_rpc, e_upc;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, input logic iv, input logic [31:0] ipc, input logic ipt,
                     input logic [31:0] itgt, input logic stl, input logic br, input logic jp,
                     input logic cond, input logic [31:0] tgt, input logic fl,
                     input logic [31:0] rpc, input logic uv, input logic ut,
                     input logic [31:0] upc, input logic cpc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ipc = ipc; v.ipt = ipt; v.itgt = itgt; v.stl = stl;
    v.br = br; v.jp = jp; v.cond = cond; v.tgt = tgt;
    v.e_fl = fl; v.e_rpc = rpc; v.e_uv = uv; v.e_ut = ut; v.e_upc = upc; v.cpc = cpc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle();
    reset = 1'b0; if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pred_target = '0;
    stall = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_cond = 1'b0; ex_target = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // rst iv ipc ipt itgt stl br jp cond tgt | fl rpc uv ut upc cpc
    // Correct not-taken branch
    add(0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h180,         0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 1, 0, 'h100, 1);
    // Taken branch with wrong predicted target; younger entries must be squashed
    add(0, 1, 'h200, 1, 'h240, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    add(0, 1, 'h204, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0);
    add(0, 1, 'h208, 1, 'h500, 0, 1, 0, 1, 'h260, 1, 'h260, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h260,         0, 0, 1, 1, 'h200, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h260,         0, 0, 0, 0, 0, 0);
    // Predicted taken, actually not taken
    add(0, 1, 'h300, 1, 'h340, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h340,         1, 'h304, 0, 0, 0, 0);
    // Non-control instruction predicted taken
    add(0, 1, 'h400, 1, 'h480, 0, 0, 0, 0, 0,     0, 0, 1, 0, 'h300, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 'h404, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    // Two-cycle stall with branch held in ID
    add(0, 1, 'h500, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0);
    add(0, 1, 'h600, 0, 0, 1, 1, 0, 1, 'h520,     0, 0, 0, 0, 0, 0);
    add(0, 1, 'h600, 0, 0, 1, 1, 0, 1, 'h520,     0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 'h520,         0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 'h520,         1, 'h520, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 1, 1, 'h500, 1);
    // Stall and flush together: held ID entry must be discarded
    add(0, 1, 'h700, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0);
    add(0, 1, 'h710, 1, 'h900, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 'h7a0,         1, 'h7a0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h7a0,         0, 0, 1, 1, 'h700, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h7a0,         0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    // Reset with a mispredicting jump in ID
    add(0, 1, 'h800, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h880,         0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h880,         0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    // Fall-through redirect wraps past the top of the address space
    add(0, 1, 'hFFFFFFFC, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h10,          1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 1, 0, 'hFFFFFFFC, 1);
    // Correctly predicted taken jump
    add(0, 1, 'h1000, 1, 'h2000, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 'h2000,        0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 1, 1, 'h1000, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; if_valid = vq[i].iv; if_pc = vq[i].ipc;
      if_pred_taken = vq[i].ipt; if_pred_target = vq[i].itgt; stall = vq[i].stl;
      ex_is_branch = vq[i].br; ex_is_jump = vq[i].jp; ex_cond = vq[i].cond;
      ex_target = vq[i].tgt;
      #1;
      chk($sformatf("row%0d flush", i), {31'b0, flush}, {31'b0, vq[i].e_fl});
      chk($sformatf("row%0d redirect_pc", i), redirect_pc, vq[i].e_rpc);
      chk($sformatf("row%0d upd_valid", i), {31'b0, upd_valid}, {31'b0, vq[i].e_uv});
      chk($sformatf("row%0d upd_taken", i), {31'b0, upd_taken}, {31'b0, vq[i].e_ut});
      if (vq[i].cpc || vq[i].e_uv) begin
        chk($sformatf("row%0d upd_pc", i), upd_pc, vq[i].e_upc);
      end
    end

`ifdef BP_STATS_EN
    // Since the reset row: two control instructions, one mispredict
    chk("stats control_cnt", {28'b0, control_cnt}, 32'd2);
    chk("stats mispredict_cnt", {28'b0, mispredict_cnt}, 32'd1);
    // Back-to-back mispredicting jumps; one resolves every third cycle
    for (int c = 0; c < 75; c++) begin
      @(negedge clk);
      idle();
      if_valid = 1'b1; if_pc = 32'h3000 + 32'(c * 4); if_pred_taken = 1'b0;
      ex_is_jump = 1'b1; ex_target = 32'h5000;
    end
    @(negedge clk);
    idle();
    #1;
    chk("sat control_cnt", {28'b0, control_cnt}, 32'd15);
    chk("sat mispredict_cnt", {28'b0, mispredict_cnt}, 32'd15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
